mem_access_ctrl: RTL and testbench

- Initiator side of the 512 x 32 main-memory interface.
- Sits between the CPU control unit and the RAM. Owns the MAR, the write-data (MDR-out) register and the read-capture MDR.
- Sequences a level-sensitive read or write strobe toward the RAM, and returns read data or a write acknowledge to the control unit over a valid/ready handshake.

---
 rtl/cpu_mem_pkg.sv | 17 +
 rtl/mem_strobe_timer.sv | 28 ++
 rtl/mem_access_ctrl.sv | 110 +++++++++++
 tb/tb_mem_access_ctrl.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_mem_pkg.sv
// Shared types and constants for the CPU main-memory interface.
// Holds the access FSM state encoding and the default bus widths.
package cpu_mem_pkg;

  localparam int DEF_ADDR_W = 9;
  localparam int DEF_DATA_W = 32;
  localparam int RAM_DEPTH  = 512;
  localparam int CNT_W      = 4;

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    STROBE,
    RESP
  } state_t;

endpackage

// File: rtl/mem_strobe_timer.sv
// Loadable down-counter that times how long the RAM strobe stays high.
// It saturates at zero, and the zero flag marks the last strobe cycle.
module mem_strobe_timer #(
  parameter int CNT_W = cpu_mem_pkg::CNT_W
) (
  input  logic             clock,
  input  logic             clear,
  input  logic             load,
  input  logic             dec,
  input  logic [CNT_W-1:0] load_val,
  output logic             zero
);

  logic [CNT_W-1:0] count;

  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (dec && (count != '0)) begin
      count <= count - 1'b1;
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/mem_access_ctrl.sv
// Initiator side of the main-memory port: owns the MAR, MDR-out and MDR.
// It sequences one RAM strobe per request and answers over a valid/ready handshake.
module mem_access_ctrl #(
  parameter int ADDR_W        = cpu_mem_pkg::DEF_ADDR_W,
  parameter int DATA_W        = cpu_mem_pkg::DEF_DATA_W,
  parameter int STROBE_CYCLES = 2
) (
  input  logic              clock,
  input  logic              clear,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              ram_read,
  output logic              ram_write,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata
);

  import cpu_mem_pkg::*;

  if (STROBE_CYCLES < 1 || STROBE_CYCLES > 15) begin : g_bad_strobe
    $error("mem_access_ctrl: STROBE_CYCLES must be within 1..15");
  end

  state_t            state;
  logic              op_write;
  logic [DATA_W-1:0] mdr;
  logic              timer_load;
  logic              timer_dec;
  logic              timer_zero;
  logic [CNT_W-1:0]  timer_init;

  assign timer_load = (state == SETUP);
  assign timer_dec  = (state == STROBE);
  assign timer_init = CNT_W'(STROBE_CYCLES - 1);

  mem_strobe_timer #(
    .CNT_W(CNT_W)
  ) u_timer (
    .clock    (clock),
    .clear    (clear),
    .load     (timer_load),
    .dec      (timer_dec),
    .load_val (timer_init),
    .zero     (timer_zero)
  );

  // ram_addr/ram_wdata are the MAR and MDR-out; they only load in IDLE so they
  // stay frozen from SETUP through RESP while the strobe is active.
  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      state     <= IDLE;
      op_write  <= 1'b0;
      req_ready <= 1'b1;
      rsp_valid <= 1'b0;
      ram_read  <= 1'b0;
      ram_write <= 1'b0;
      ram_addr  <= '0;
      ram_wdata <= '0;
      mdr       <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            ram_addr  <= req_addr;
            ram_wdata <= req_wdata;
            op_write  <= req_write;
            req_ready <= 1'b0;
            state     <= SETUP;
          end
        end
        SETUP: begin
          ram_read  <= ~op_write;
          ram_write <= op_write;
          state     <= STROBE;
        end
        STROBE: begin
          if (timer_zero) begin
            ram_read  <= 1'b0;
            ram_write <= 1'b0;
            if (!op_write) begin
              mdr <= ram_rdata;
            end
            rsp_valid <= 1'b1;
            state     <= RESP;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            req_ready <= 1'b1;
            state     <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign rsp_rdata = mdr;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Bench for mem_access_ctrl: three instances (strobe widths 2, 1, 15) against
// a behavioural RAM and a word-level reference model of memory and MDR.
module tb_mem_access_ctrl;

  localparam int ND = 3;

  logic        clock;
  logic        preload;
  logic        clear     [ND];
  logic        req_valid [ND];
  logic        req_ready [ND];
  logic        req_write [ND];
  logic [8:0]  req_addr  [ND];
  logic [31:0] req_wdata [ND];
  logic        rsp_valid [ND];
  logic        rsp_ready [ND];
  logic [31:0] rsp_rdata [ND];
  logic        ram_read  [ND];
  logic        ram_write [ND];
  logic [8:0]  ram_addr  [ND];
  logic [31:0] ram_wdata [ND];
  logic [31:0] ram_rdata [ND];

  logic [31:0] ram_mem [ND][512];
  logic [31:0] ref_mem [ND][512];
  logic [31:0] mdr_m   [ND];

  int checks = 0;
  int errors = 0;

  function automatic int strobe_n(input int d);
    return (d == 0) ? 2 : ((d == 1) ? 1 : 15);
  endfunction

  function automatic logic [31:0] init_word(input int d, input int i);
    if (i == 0) return 32'h1234_5678;
    return 32'hA5A5_0000 ^ (32'(d) << 24) ^ (32'(i) * 32'h0001_3579);
  endfunction

  for (genvar g = 0; g < ND; g++) begin : g_dut
    mem_access_ctrl #(
      .ADDR_W        (9),
      .DATA_W        (32),
      .STROBE_CYCLES ((g == 0) ? 2 : ((g == 1) ? 1 : 15))
    ) u_dut (
      .clock     (clock),
      .clear     (clear[g]),
      .req_valid (req_valid[g]),
      .req_ready (req_ready[g]),
      .req_write (req_write[g]),
      .req_addr  (req_addr[g]),
      .req_wdata (req_wdata[g]),
      .rsp_valid (rsp_valid[g]),
      .rsp_ready (rsp_ready[g]),
      .rsp_rdata (rsp_rdata[g]),
      .ram_read  (ram_read[g]),
      .ram_write (ram_write[g]),
      .ram_addr  (ram_addr[g]),
      .ram_wdata (ram_wdata[g]),
      .ram_rdata (ram_rdata[g])
    );
    assign ram_rdata[g] = ram_read[g] ? ram_mem[g][ram_addr[g]] : 'x;
  end

  always #5 clock = ~clock;

  // Behavioural RAM: one-shot preload, then written whenever the write strobe is high.
  always @(posedge clock) begin
    if (preload) begin
      for (int d = 0; d < ND; d++)
        for (int i = 0; i < 512; i++)
          ram_mem[d][i] <= init_word(d, i);
    end else begin
      for (int d = 0; d < ND; d++)
        if (ram_write[d] === 1'b1) ram_mem[d][ram_addr[d]] <= ram_wdata[d];
    end
  end

  always @(negedge clock) begin
    for (int d = 0; d < ND; d++) begin
      checks++;
      assert (!(ram_read[d] === 1'b1 && ram_write[d] === 1'b1)) else begin
        errors++;
        $error("[TB] FAIL d%0d strobe_exclusive observed=both expected=one", d);
      end
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // One complete access; optionally leaves the next request pending during RESP.
  task automatic applyStimulus(input int d, input bit wr, input logic [8:0] addr,
                               input logic [31:0] wdata, input int delay, input bit pend,
                               input bit pwr, input logic [8:0] paddr, input logic [31:0] pwdata);
    int n, cnt, first, rspc, bad, hold;
    logic [31:0] exp;
    n     = strobe_n(d);
    exp   = wr ? mdr_m[d] : ref_mem[d][addr];
    cnt   = 0;
    first = -1;
    rspc  = -1;
    bad   = 0;
    hold  = 0;
    checkOutput($sformatf("d%0d idle_ready", d), 32'(req_ready[d]), 32'd1);
    req_valid[d] = 1'b1;
    req_write[d] = wr;
    req_addr[d]  = addr;
    req_wdata[d] = wdata;
    @(negedge clock);
    req_valid[d] = 1'b0;
    req_write[d] = 1'($urandom);
    req_addr[d]  = 9'($urandom);
    req_wdata[d] = $urandom;
    checkOutput($sformatf("d%0d setup_ready", d), 32'(req_ready[d]), 32'd0);
    checkOutput($sformatf("d%0d setup_strobes", d), 32'({ram_read[d], ram_write[d]}), 32'd0);
    checkOutput($sformatf("d%0d setup_addr", d), 32'(ram_addr[d]), 32'(addr));
    checkOutput($sformatf("d%0d setup_wdata", d), ram_wdata[d], wdata);
    for (int c = 2; c <= 40; c++) begin
      @(negedge clock);
      if ((wr ? ram_write[d] : ram_read[d]) === 1'b1) begin
        cnt++;
        if (first < 0) first = c;
      end
      if ((wr ? ram_read[d] : ram_write[d]) !== 1'b0) bad++;
      if (ram_addr[d] !== addr || ram_wdata[d] !== wdata) hold++;
      if (rsp_valid[d] === 1'b1) begin
        rspc = c;
        break;
      end
    end
    checkOutput($sformatf("d%0d strobe_width", d), 32'(cnt), 32'(n));
    checkOutput($sformatf("d%0d strobe_start", d), 32'(first), 32'd2);
    checkOutput($sformatf("d%0d rsp_cycle", d), 32'(rspc), 32'(n + 2));
    checkOutput($sformatf("d%0d wrong_strobe", d), 32'(bad), 32'd0);
    checkOutput($sformatf("d%0d addr_hold", d), 32'(hold), 32'd0);
    checkOutput($sformatf("d%0d rsp_rdata", d), rsp_rdata[d], exp);
    if (wr) ref_mem[d][addr] = wdata;
    else    mdr_m[d] = exp;
    if (pend) begin
      req_valid[d] = 1'b1;
      req_write[d] = pwr;
      req_addr[d]  = paddr;
      req_wdata[d] = pwdata;
    end
    for (int i = 0; i < delay; i++) begin
      checkOutput($sformatf("d%0d bp_rsp_valid", d), 32'(rsp_valid[d]), 32'd1);
      checkOutput($sformatf("d%0d bp_req_ready", d), 32'(req_ready[d]), 32'd0);
      checkOutput($sformatf("d%0d bp_addr_hold", d), 32'(ram_addr[d]), 32'(addr));
      @(negedge clock);
    end
    rsp_ready[d] = 1'b1;
    @(negedge clock);
    rsp_ready[d] = 1'b0;
    checkOutput($sformatf("d%0d done_rsp_valid", d), 32'(rsp_valid[d]), 32'd0);
    checkOutput($sformatf("d%0d done_req_ready", d), 32'(req_ready[d]), 32'd1);
    checkOutput($sformatf("d%0d done_rdata", d), rsp_rdata[d], mdr_m[d]);
  endtask

  initial begin
    bit          cwr, nwr, pend;
    logic [8:0]  caddr, naddr;
    logic [31:0] cdata, ndata, sdata;

    clock   = 1'b0;
    preload = 1'b1;
    for (int d = 0; d < ND; d++) begin
      clear[d] = 1'b1;
      req_valid[d] = 1'b0; req_write[d] = 1'b0; req_addr[d] = '0;
      req_wdata[d] = '0;   rsp_ready[d] = 1'b0; mdr_m[d] = '0;
      for (int i = 0; i < 512; i++) ref_mem[d][i] = init_word(d, i);
    end

    // Reset with random inputs: every output must sit at its reset value.
    for (int k = 0; k < 3; k++) begin
      for (int d = 0; d < ND; d++) begin
        req_valid[d] = 1'($urandom); req_write[d] = 1'($urandom);
        req_addr[d]  = 9'($urandom); req_wdata[d] = $urandom;
        rsp_ready[d] = 1'($urandom);
      end
      @(negedge clock);
      preload = 1'b0;
      for (int d = 0; d < ND; d++) begin
        checkOutput($sformatf("d%0d rst_req_ready", d), 32'(req_ready[d]), 32'd1);
        checkOutput($sformatf("d%0d rst_rsp_valid", d), 32'(rsp_valid[d]), 32'd0);
        checkOutput($sformatf("d%0d rst_ram_read", d), 32'(ram_read[d]), 32'd0);
        checkOutput($sformatf("d%0d rst_ram_write", d), 32'(ram_write[d]), 32'd0);
        checkOutput($sformatf("d%0d rst_ram_addr", d), 32'(ram_addr[d]), 32'd0);
        checkOutput($sformatf("d%0d rst_ram_wdata", d), ram_wdata[d], 32'd0);
        checkOutput($sformatf("d%0d rst_rsp_rdata", d), rsp_rdata[d], 32'd0);
      end
    end
    for (int d = 0; d < ND; d++) begin
      req_valid[d] = 1'b0; rsp_ready[d] = 1'b0; clear[d] = 1'b0;
    end
    @(negedge clock);

    // Store at the top address, then a backpressured load of address 0 with a pending request.
    applyStimulus(0, 1'b1, 9'h1FF, 32'hDEAD_BEEF, 0, 1'b0, 1'b0, '0, '0);
    applyStimulus(0, 1'b0, 9'h000, 32'h0, 5, 1'b1, 1'b0, 9'h1FF, 32'h0);
    applyStimulus(0, 1'b0, 9'h1FF, 32'h0, 0, 1'b0, 1'b0, '0, '0);

    // Clear during the second strobe cycle of a load.
    req_valid[0] = 1'b1; req_write[0] = 1'b0; req_addr[0] = 9'h000; req_wdata[0] = '0;
    @(negedge clock);
    req_valid[0] = 1'b0;
    @(negedge clock);
    checkOutput("d0 midrst_strobe1", 32'(ram_read[0]), 32'd1);
    @(negedge clock);
    checkOutput("d0 midrst_strobe2", 32'(ram_read[0]), 32'd1);
    #2 clear[0] = 1'b1;
    #1;
    checkOutput("d0 midrst_read_drop", 32'(ram_read[0]), 32'd0);
    checkOutput("d0 midrst_mdr", rsp_rdata[0], 32'd0);
    checkOutput("d0 midrst_req_ready", 32'(req_ready[0]), 32'd1);
    @(negedge clock);
    clear[0] = 1'b0;
    mdr_m[0] = '0;
    @(negedge clock);
    applyStimulus(0, 1'b0, 9'h000, 32'h0, 1, 1'b0, 1'b0, '0, '0);

    // Random traffic with occasional pending requests during the response.
    cwr = 1'($urandom); caddr = 9'($urandom); cdata = $urandom;
    for (int t = 0; t < 10; t++) begin
      nwr   = 1'($urandom);
      naddr = ($urandom_range(0, 3) == 0) ? 9'h1FF : 9'($urandom);
      ndata = $urandom;
      pend  = 1'($urandom);
      applyStimulus(0, cwr, caddr, cdata, $urandom_range(0, 3), pend, nwr, naddr, ndata);
      cwr = nwr; caddr = naddr; cdata = ndata;
    end

    // Narrowest and widest strobe settings.
    for (int d = 1; d < ND; d++) begin
      caddr = 9'($urandom);
      sdata = $urandom;
      applyStimulus(d, 1'b1, caddr, sdata, 0, 1'b0, 1'b0, '0, '0);
      applyStimulus(d, 1'b0, caddr, 32'h0, 2, 1'b1, 1'b0, 9'h000, 32'h0);
      applyStimulus(d, 1'b0, 9'h000, 32'h0, 0, 1'b0, 1'b0, '0, '0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
